// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM.
// Sequences the shared-memory / ALU / register-file datapath one step per cycle.
// Memory states stall on MemReady. A stall that lasts too long traps the machine.
// An unsupported opcode also traps the machine.
// Control outputs decode from the current state only; FETCH additionally gates
// IRWrite/PCWrite with MemReady so the PC and IR update exactly once per fetch.
module mips_multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] State,
    output logic       Illegal,
    output logic       Timeout
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_MEM_ADDR  = 4'd3;
    localparam logic [3:0] S_MEM_READ  = 4'd4;
    localparam logic [3:0] S_MEM_WB    = 4'd5;
    localparam logic [3:0] S_MEM_WRITE = 4'd6;
    localparam logic [3:0] S_R_EXEC    = 4'd7;
    localparam logic [3:0] S_R_WB      = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JUMP      = 4'd10;
    localparam logic [3:0] S_ADDI_EXEC = 4'd11;
    localparam logic [3:0] S_ADDI_WB   = 4'd12;
    localparam logic [3:0] S_TRAP      = 4'd15;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

    logic [3:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [5:0] op_q, op_d;
    logic       illegal_q, illegal_d;
    logic       timeout_q, timeout_d;
    logic       mem_state_s;
    logic       trap_s;

    // A memory state that is still waiting has exhausted its budget.
    assign mem_state_s = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                         (state_q == S_MEM_WRITE);
    assign trap_s      = mem_state_s && !MemReady && (cnt_q == TIMEOUT_LIM);

    // Next-state, captured opcode, wait counter and sticky fault flags.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q | trap_s;
        case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH: begin
                if (MemReady)    state_d = S_DECODE;
                else if (trap_s) state_d = S_TRAP;
                else             state_d = S_FETCH;
            end
            S_DECODE: begin
                op_d = Opcode;
                case (Opcode)
                    OP_R:         state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                if (op_q == OP_SW) state_d = S_MEM_WRITE;
                else               state_d = S_MEM_READ;
            end
            S_MEM_READ: begin
                if (MemReady)    state_d = S_MEM_WB;
                else if (trap_s) state_d = S_TRAP;
                else             state_d = S_MEM_READ;
            end
            S_MEM_WRITE: begin
                if (MemReady)    state_d = S_FETCH;
                else if (trap_s) state_d = S_TRAP;
                else             state_d = S_MEM_WRITE;
            end
            S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_R_EXEC:    state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_IDLE;
        endcase

        if (state_d != state_q)           cnt_d = 8'd0;
        else if (mem_state_s && !MemReady) cnt_d = cnt_q + 8'd1;
        else                               cnt_d = cnt_q;
    end

    // State and bookkeeping registers; reset forces IDLE with flags cleared.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            op_q      <= 6'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Datapath control decode from the current state.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_ADDI_WB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            default: PCWrite = 1'b0;
        endcase
    end

    assign State   = state_q;
    assign Illegal = illegal_q;
    assign Timeout = timeout_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed testbench for mips_multicycle_ctrl.
// Each cycle the bench drives the inputs on the falling edge and pushes the expected output vector.
// It then pops that vector and compares it against the DUT outputs 1ns later.
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       CLK = 1'b0;
    logic       Reset = 1'b0;
    logic [5:0] Opcode = 6'd0;
    logic       MemReady = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Illegal, Timeout;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          pcw_fetch = 0;
    logic        exp_ill = 1'b0;
    logic        exp_to  = 1'b0;
    logic [21:0] sb [$];
    logic [21:0] obs;

    mips_multicycle_ctrl dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .State(State), .Illegal(Illegal), .Timeout(Timeout)
    );

    always #5 CLK = ~CLK;

    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, State,
                  Illegal, Timeout};

    // Expected control vector for a state, written from the output table.
    function automatic logic [21:0] expv(input logic [3:0] s, input logic mr,
                                         input logic il, input logic to);
        logic pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, psrc;
        {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = 10'd0;
        asb = 2'd0; aop = 2'd0; psrc = 2'd0;
        case (s)
            4'd1:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
            4'd2:  asb = 2'b11;
            4'd3:  begin asa = 1'b1; asb = 2'b10; end
            4'd4:  begin mrd = 1'b1; iord = 1'b1; end
            4'd5:  begin rw = 1'b1; m2r = 1'b1; end
            4'd6:  begin mwr = 1'b1; iord = 1'b1; end
            4'd7:  begin asa = 1'b1; aop = 2'b10; end
            4'd8:  begin rw = 1'b1; rdst = 1'b1; end
            4'd9:  begin asa = 1'b1; aop = 2'b01; pcc = 1'b1; psrc = 2'b01; end
            4'd10: begin pcw = 1'b1; psrc = 2'b10; end
            4'd11: begin asa = 1'b1; asb = 2'b10; end
            4'd12: rw = 1'b1;
            default: pcw = 1'b0;
        endcase
        return {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, s, il, to};
    endfunction

    task automatic compare(input string tag);
        logic [21:0] e;
        e = sb.pop_front();
        n_tests++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic cyc(input string tag, input logic mr, input logic [5:0] op,
                       input logic [3:0] s);
        @(negedge CLK);
        MemReady = mr;
        Opcode   = op;
        sb.push_back(expv(s, mr, exp_ill, exp_to));
        #1;
        compare(tag);
        if (State == 4'd1 && PCWrite === 1'b1) pcw_fetch++;
    endtask

    // Zero-wait instruction: n states packed as nibbles from the top of seq.
    task automatic run(input string tag, input logic [5:0] op, input int n,
                       input logic [23:0] seq);
        for (int i = 0; i < n; i++) cyc(tag, 1'b1, op, seq[23 - 4*i -: 4]);
    endtask

    task automatic do_reset();
        Reset   = 1'b0;
        exp_ill = 1'b0;
        exp_to  = 1'b0;
        cyc("reset", 1'b0, 6'd0, 4'd0);
        Reset = 1'b1;
    endtask

    initial begin
        do_reset();

        // Zero-wait sequence of all six instruction classes.
        pcw_fetch = 0;
        run("r",    OP_R,    4, 24'h127800);
        run("beq",  OP_BEQ,  3, 24'h129000);
        run("lw",   OP_LW,   5, 24'h123450);
        run("sw",   OP_SW,   4, 24'h123600);
        run("j",    OP_J,    3, 24'h12A000);
        run("addi", OP_ADDI, 4, 24'h12BC00);
        n_tests++;
        assert (pcw_fetch === 6) else begin
            n_fail++;
            $error("FAIL pcwrite_per_fetch: observed %0d expected %0d", pcw_fetch, 6);
        end

        // lw with three wait cycles in MEM_READ.
        run("lw_wait", OP_LW, 3, 24'h123000);
        for (int i = 0; i < 3; i++) cyc("lw_wait_hold", 1'b0, OP_LW, 4'd4);
        cyc("lw_wait_ready", 1'b1, OP_LW, 4'd4);
        cyc("lw_wait_wb", 1'b1, OP_LW, 4'd5);
        cyc("lw_wait_fetch", 1'b1, OP_R, 4'd1);

        // Asynchronous reset in the middle of MEM_READ.
        cyc("rst_mid_dec", 1'b1, OP_LW, 4'd2);
        cyc("rst_mid_addr", 1'b1, OP_LW, 4'd3);
        cyc("rst_mid_read", 1'b0, OP_LW, 4'd4);
        #2;
        Reset = 1'b0;
        sb.push_back(expv(4'd0, 1'b0, 1'b0, 1'b0));
        #1;
        compare("rst_async");
        cyc("rst_hold", 1'b0, 6'd0, 4'd0);
        Reset = 1'b1;
        cyc("rst_release", 1'b0, 6'd0, 4'd1);

        // Illegal opcode traps and stays trapped.
        cyc("ill_fetch", 1'b1, OP_BAD, 4'd1);
        cyc("ill_decode", 1'b1, OP_BAD, 4'd2);
        exp_ill = 1'b1;
        cyc("ill_trap0", 1'b1, OP_R, 4'd15);
        cyc("ill_trap1", 1'b0, OP_R, 4'd15);
        cyc("ill_trap2", 1'b1, OP_LW, 4'd15);

        // Fetch stall exceeding the wait budget traps with Timeout.
        do_reset();
        for (int i = 0; i < 16; i++) cyc("to_fetch_wait", 1'b0, OP_R, 4'd1);
        exp_to = 1'b1;
        cyc("to_trap0", 1'b0, OP_R, 4'd15);
        cyc("to_trap1", 1'b1, OP_R, 4'd15);

        // Ready on the boundary cycle wins over the timeout.
        do_reset();
        for (int i = 0; i < 15; i++) cyc("bnd_fetch_wait", 1'b0, OP_R, 4'd1);
        cyc("bnd_fetch_ready", 1'b1, OP_R, 4'd1);
        cyc("bnd_decode", 1'b1, OP_R, 4'd2);
        cyc("bnd_rexec", 1'b1, OP_R, 4'd7);
        cyc("bnd_rwb", 1'b1, OP_R, 4'd8);
        cyc("bnd_fetch", 1'b1, OP_R, 4'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
